// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - instruction fetch PC register and IF/ID pipeline register
// Handles reset, exception entry, eret return, stall, jump and sequential fetch.
module fetch_pc (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] next_pc,
   input  logic        if_jump,
   input  logic        stall,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] d_instr,
   output logic [31:0] d_pc,
   output logic [31:0] d_pc_4,
   output logic        d_bd,
   output logic        d_exc_valid,
   output logic [4:0]  d_exccode
);

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC   = 32'h0000_4180;
   localparam logic [31:0] IMEM_LO  = 32'h0000_3000;
   localparam logic [31:0] IMEM_HI  = 32'h0000_4FFC;
   localparam logic [4:0]  ADEL     = 5'd4;

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] dpc_q, dpc_d;
   logic [31:0] dpc4_q, dpc4_d;
   logic        bd_q, bd_d;
   logic        excv_q, excv_d;
   logic [4:0]  code_q, code_d;
   logic [31:0] pc_plus4;
   logic        fetch_err;

   assign pc_plus4  = pc_q + 32'd4;
   assign fetch_err = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI);

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      dpc_d   = dpc_q;
      dpc4_d  = dpc4_q;
      bd_d    = bd_q;
      excv_d  = excv_q;
      code_d  = code_q;
      if (exc_req || eret_req) begin
         // Both redirects discard the instruction in fetch, so no delay slot survives.
         pc_d    = exc_req ? EXC_PC : epc;
         instr_d = 32'd0;
         dpc_d   = 32'd0;
         dpc4_d  = 32'd0;
         bd_d    = 1'b0;
         excv_d  = 1'b0;
         code_d  = 5'd0;
      end else if (!stall) begin
         pc_d    = if_jump ? next_pc : pc_plus4;
         instr_d = fetch_err ? 32'd0 : imem_rdata;
         dpc_d   = pc_q;
         dpc4_d  = pc_plus4;
         bd_d    = if_jump;
         excv_d  = fetch_err;
         code_d  = fetch_err ? ADEL : 5'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         instr_q <= 32'd0;
         dpc_q   <= 32'd0;
         dpc4_q  <= 32'd0;
         bd_q    <= 1'b0;
         excv_q  <= 1'b0;
         code_q  <= 5'd0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         dpc_q   <= dpc_d;
         dpc4_q  <= dpc4_d;
         bd_q    <= bd_d;
         excv_q  <= excv_d;
         code_q  <= code_d;
      end
   end

   assign imem_addr   = pc_q;
   assign d_instr     = instr_q;
   assign d_pc        = dpc_q;
   assign d_pc_4      = dpc4_q;
   assign d_bd        = bd_q;
   assign d_exc_valid = excv_q;
   assign d_exccode   = code_q;

endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - scoreboard bench for fetch_pc with directed vectors
module tb_fetch_pc;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] next_pc = 32'd0;
   logic        if_jump = 1'b0;
   logic        stall = 1'b0;
   logic        exc_req = 1'b0;
   logic        eret_req = 1'b0;
   logic [31:0] epc = 32'd0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] d_instr;
   logic [31:0] d_pc;
   logic [31:0] d_pc_4;
   logic        d_bd;
   logic        d_exc_valid;
   logic [4:0]  d_exccode;

   int tests = 0;
   int fails = 0;

   localparam int K_NORM  = 0;
   localparam int K_FLUSH = 1;
   localparam int K_FAULT = 2;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        bd;
      logic        ev;
      logic [4:0]  code;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   // Instruction memory returns a tag plus the low address half.
   assign imem_rdata = {16'hA5A5, imem_addr[15:0]};

   fetch_pc dut (
      .clk(clk), .reset(reset), .next_pc(next_pc), .if_jump(if_jump),
      .stall(stall), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .d_instr(d_instr),
      .d_pc(d_pc), .d_pc_4(d_pc_4), .d_bd(d_bd), .d_exc_valid(d_exc_valid),
      .d_exccode(d_exccode)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("imem_addr", imem_addr, e.addr);
         chk("d_pc", d_pc, e.pc);
         chk("d_pc_4", d_pc_4, e.pc4);
         chk("d_instr", d_instr, e.instr);
         chk("d_bd", {31'd0, d_bd}, {31'd0, e.bd});
         chk("d_exc_valid", {31'd0, d_exc_valid}, {31'd0, e.ev});
         chk("d_exccode", {27'd0, d_exccode}, {27'd0, e.code});
      end
   end

   // Apply inputs on the falling edge and queue the state expected after the next rising edge.
   task automatic step(input logic rst, input logic exc, input logic eret, input logic stl,
                       input logic jmp, input logic [31:0] npc, input logic [31:0] ep,
                       input logic [31:0] x_addr, input int kind, input logic [31:0] x_pc,
                       input logic x_bd);
      exp_t e;
      @(negedge clk);
      reset = rst; exc_req = exc; eret_req = eret; stall = stl;
      if_jump = jmp; next_pc = npc; epc = ep;
      e.addr = x_addr;
      if (kind == K_FLUSH) begin
         e.pc = 32'd0; e.pc4 = 32'd0; e.instr = 32'd0; e.bd = 1'b0; e.ev = 1'b0; e.code = 5'd0;
      end else begin
         e.pc  = x_pc;
         e.pc4 = x_pc + 32'd4;
         e.bd  = x_bd;
         e.ev  = (kind == K_FAULT);
         e.code  = (kind == K_FAULT) ? 5'd4 : 5'd0;
         e.instr = (kind == K_FAULT) ? 32'd0 : {16'hA5A5, x_pc[15:0]};
      end
      sb.push_back(e);
   endtask

   initial begin
      //    rst exc ert stl jmp next_pc        epc           exp addr       kind     exp d_pc       bd
      step(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_3000, K_FLUSH, 32'h0,         0);
      step(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_3004, K_NORM,  32'h0000_3000, 0);
      step(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_3008, K_NORM,  32'h0000_3004, 0);
      step(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_300C, K_NORM,  32'h0000_3008, 0);
      step(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_3010, K_NORM,  32'h0000_300C, 0);
      step(0, 0, 0, 0, 1, 32'h0000_3100, 32'h0,       32'h0000_3100, K_NORM,  32'h0000_3010, 1);
      step(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_3104, K_NORM,  32'h0000_3100, 0);
      step(0, 0, 0, 0, 1, 32'h0000_3020, 32'h0,       32'h0000_3020, K_NORM,  32'h0000_3104, 1);
      step(0, 0, 0, 1, 1, 32'h0000_3200, 32'h0,       32'h0000_3020, K_NORM,  32'h0000_3104, 1);
      step(0, 0, 0, 1, 1, 32'h0000_3200, 32'h0,       32'h0000_3020, K_NORM,  32'h0000_3104, 1);
      step(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_3024, K_NORM,  32'h0000_3020, 0);
      step(0, 0, 0, 0, 1, 32'h0000_3040, 32'h0,       32'h0000_3040, K_NORM,  32'h0000_3024, 1);
      step(0, 1, 1, 1, 1, 32'h0000_3300, 32'h0000_3008, 32'h0000_4180, K_FLUSH, 32'h0,     0);
      step(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_4184, K_NORM,  32'h0000_4180, 0);
      step(0, 0, 1, 0, 1, 32'h0000_3300, 32'h0000_3008, 32'h0000_3008, K_FLUSH, 32'h0,     0);
      step(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_300C, K_NORM,  32'h0000_3008, 0);
      step(0, 0, 0, 0, 1, 32'h0000_3002, 32'h0,       32'h0000_3002, K_NORM,  32'h0000_300C, 1);
      step(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_3006, K_FAULT, 32'h0000_3002, 0);
      step(0, 0, 0, 0, 1, 32'h0000_5000, 32'h0,       32'h0000_5000, K_FAULT, 32'h0000_3006, 1);
      step(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_5004, K_FAULT, 32'h0000_5000, 0);
      step(0, 0, 0, 0, 1, 32'h0000_2FFC, 32'h0,       32'h0000_2FFC, K_FAULT, 32'h0000_5004, 1);
      step(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_3000, K_FAULT, 32'h0000_2FFC, 0);
      step(1, 1, 0, 1, 1, 32'h0000_3300, 32'h0,       32'h0000_3000, K_FLUSH, 32'h0,         0);
      step(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_3004, K_NORM,  32'h0000_3000, 0);
      step(0, 0, 0, 0, 1, 32'h0000_4FFC, 32'h0,       32'h0000_4FFC, K_NORM,  32'h0000_3004, 1);
      step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, K_NORM,  32'h0000_4FFC, 1);
      step(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0000, K_FAULT, 32'hFFFF_FFFC, 0);
      @(negedge clk);
      reset = 0; exc_req = 0; eret_req = 0; stall = 0; if_jump = 0;
      repeat (3) @(negedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
